// File: rtl/router_fsm_n.sv
// Packet-router control FSM for an N-output router: header decode, wait-for-empty
// with timeout, data/parity load sequencing, back-pressure and invalid-address drop.
module router_fsm_n #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2,
  parameter int WAIT_MAX  = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 pkt_valid,
  input  logic                 low_pkt_valid,
  input  logic                 parity_done,
  input  logic [ADDR_W-1:0]    din,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] sftrst,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 we_reg,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 drop_state,
  output logic                 addr_err,
  output logic                 wait_timeout
);

  localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
  localparam logic [ADDR_W:0]  NP        = (ADDR_W + 1)'(NUM_PORTS);

  typedef enum logic [3:0] {
    DECODE_ADDR,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR,
    DROP_PKT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                addr_err_q, wait_timeout_q;

  logic                 empty_din, empty_sel, full_sel, sft_sel, din_bad, timeout;
  logic [NUM_PORTS-1:0] onehot;

  // Per-port selects by the incoming header address and by the latched address
  always_comb begin
    empty_din = 1'b0;
    empty_sel = 1'b0;
    full_sel  = 1'b0;
    sft_sel   = 1'b0;
    onehot    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (din == ADDR_W'(i)) empty_din = fifo_empty[i];
      if (addr_q == ADDR_W'(i)) begin
        empty_sel = fifo_empty[i];
        full_sel  = fifo_full[i];
        sft_sel   = sftrst[i];
        onehot[i] = 1'b1;
      end
    end
  end

  assign din_bad = ({1'b0, din} >= NP);
  assign timeout = (WAIT_MAX != 0) && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DECODE_ADDR: begin
        if (pkt_valid) begin
          addr_d = din;
          if (din_bad)        state_d = DROP_PKT;
          else if (empty_din) state_d = LOAD_FIRST_DATA;
          else                state_d = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      WAIT_TILL_EMPTY: begin
        if (empty_sel)    state_d = LOAD_FIRST_DATA;
        else if (timeout) state_d = DROP_PKT;
      end
      LOAD_DATA: begin
        if (full_sel)        state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      FIFO_FULL_STATE: begin
        if (!full_sel) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDR;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      CHECK_PARITY_ERROR: state_d = full_sel ? FIFO_FULL_STATE : DECODE_ADDR;
      DROP_PKT: begin
        if (!pkt_valid) state_d = DECODE_ADDR;
      end
      default: state_d = DECODE_ADDR;
    endcase
    // Soft reset only counts for the port this packet is headed to
    if (sft_sel && state_q != DECODE_ADDR && state_q != DROP_PKT) state_d = DECODE_ADDR;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d == WAIT_TILL_EMPTY && state_q != WAIT_TILL_EMPTY) wait_cnt_d = '0;
    else if (state_q == WAIT_TILL_EMPTY)                          wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= DECODE_ADDR;
      addr_q         <= '0;
      wait_cnt_q     <= '0;
      addr_err_q     <= 1'b0;
      wait_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wait_cnt_q     <= wait_cnt_d;
      addr_err_q     <= (state_q == DECODE_ADDR) && (state_d == DROP_PKT);
      wait_timeout_q <= (state_q == WAIT_TILL_EMPTY) && (state_d == DROP_PKT);
    end
  end

  assign detect_add   = (state_q == DECODE_ADDR);
  assign lfd_state    = (state_q == LOAD_FIRST_DATA);
  assign ld_state     = (state_q == LOAD_DATA);
  assign laf_state    = (state_q == LOAD_AFTER_FULL);
  assign full_state   = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg  = (state_q == CHECK_PARITY_ERROR);
  assign drop_state   = (state_q == DROP_PKT);
  assign we_reg       = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                        (state_q == LOAD_AFTER_FULL);
  assign busy         = !((state_q == DECODE_ADDR) || (state_q == LOAD_DATA) ||
                          (state_q == DROP_PKT));
  assign write_enb    = (lfd_state || we_reg) ? onehot : '0;
  assign addr_err     = addr_err_q;
  assign wait_timeout = wait_timeout_q;

endmodule

// File: tb/tb_router_fsm_n.sv
// Directed self-checking bench for router_fsm_n (3 ports, WAIT_MAX=4).
module tb_router_fsm_n;

  logic       clk = 1'b0;
  logic       rstn, pkt_valid, low_pkt_valid, parity_done;
  logic [1:0] din;
  logic [2:0] fifo_empty, fifo_full, sftrst;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic       we_reg, busy, drop_state, addr_err, wait_timeout;
  logic [2:0] write_enb;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected decode word: {detect,lfd,ld,laf,full,rst_int,we,busy,drop,addr_err,wait_to}
  localparam logic [10:0] O_DEC  = 11'h400;
  localparam logic [10:0] O_LFD  = 11'h208;
  localparam logic [10:0] O_LD   = 11'h110;
  localparam logic [10:0] O_LAF  = 11'h098;
  localparam logic [10:0] O_FULL = 11'h048;
  localparam logic [10:0] O_CPE  = 11'h028;
  localparam logic [10:0] O_LP   = 11'h018;
  localparam logic [10:0] O_WAIT = 11'h008;
  localparam logic [10:0] O_DROP = 11'h004;
  localparam logic [10:0] O_DAE  = 11'h006;
  localparam logic [10:0] O_DTO  = 11'h005;

  always #5 clk = ~clk;

  router_fsm_n #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_MAX(4)) dut (
    .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .low_pkt_valid(low_pkt_valid),
    .parity_done(parity_done), .din(din), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .sftrst(sftrst), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .we_reg(we_reg), .busy(busy), .write_enb(write_enb), .drop_state(drop_state),
    .addr_err(addr_err), .wait_timeout(wait_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the full decode word and the FIFO write enables together
  task automatic expect_out(input string tag, input logic [10:0] o, input logic [2:0] we);
    chk({tag, ".dec"}, {21'd0, detect_add, lfd_state, ld_state, laf_state, full_state,
        rst_int_reg, we_reg, busy, drop_state, addr_err, wait_timeout}, {21'd0, o});
    chk({tag, ".wen"}, {29'd0, write_enb}, {29'd0, we});
  endtask

  initial begin
    rstn = 1'b0; pkt_valid = 1'b0; low_pkt_valid = 1'b0; parity_done = 1'b0;
    din = 2'd0; fifo_empty = 3'b111; fifo_full = 3'b000; sftrst = 3'b000;
    step(); step();
    expect_out("reset", O_DEC, 3'b000);
    rstn = 1'b1;
    step();
    expect_out("idle", O_DEC, 3'b000);

    // Normal packet to port 2
    din = 2'd2; pkt_valid = 1'b1;
    step(); expect_out("p2.lfd", O_LFD, 3'b100);
    step(); expect_out("p2.ld", O_LD, 3'b100);
    step(); expect_out("p2.ld_hold", O_LD, 3'b100);
    pkt_valid = 1'b0;
    step(); expect_out("p2.lp", O_LP, 3'b100);
    step(); expect_out("p2.cpe", O_CPE, 3'b000);
    step(); expect_out("p2.dec", O_DEC, 3'b000);

    // Invalid address 3
    din = 2'd3; pkt_valid = 1'b1;
    step(); expect_out("bad.drop1", O_DAE, 3'b000);
    step(); expect_out("bad.drop2", O_DROP, 3'b000);
    pkt_valid = 1'b0;
    step(); expect_out("bad.dec", O_DEC, 3'b000);

    // Wait-for-empty timeout on port 1
    din = 2'd1; pkt_valid = 1'b1; fifo_empty = 3'b101;
    step(); expect_out("to.w1", O_WAIT, 3'b000);
    pkt_valid = 1'b0;
    step(); expect_out("to.w2", O_WAIT, 3'b000);
    step(); expect_out("to.w3", O_WAIT, 3'b000);
    step(); expect_out("to.w4", O_WAIT, 3'b000);
    step(); expect_out("to.drop", O_DTO, 3'b000);
    step(); expect_out("to.dec", O_DEC, 3'b000);

    // FIFO drains during the third wait cycle
    pkt_valid = 1'b1;
    step(); expect_out("we3.w1", O_WAIT, 3'b000);
    pkt_valid = 1'b0;
    step(); expect_out("we3.w2", O_WAIT, 3'b000);
    step(); expect_out("we3.w3", O_WAIT, 3'b000);
    fifo_empty = 3'b111;
    step(); expect_out("we3.lfd", O_LFD, 3'b010);
    step(); expect_out("we3.lp_via_ld", O_LD, 3'b010);
    step(); expect_out("we3.lp", O_LP, 3'b010);
    step(); expect_out("we3.cpe", O_CPE, 3'b000);
    step(); expect_out("we3.dec", O_DEC, 3'b000);

    // Empty and timeout in the same cycle: empty wins
    fifo_empty = 3'b101; pkt_valid = 1'b1;
    step(); expect_out("tie.w1", O_WAIT, 3'b000);
    step(); step(); step(); expect_out("tie.w4", O_WAIT, 3'b000);
    fifo_empty = 3'b111;
    step(); expect_out("tie.lfd", O_LFD, 3'b010);
    step(); expect_out("tie.ld", O_LD, 3'b010);

    // Soft reset qualified to addr_q=1
    sftrst = 3'b001;
    step(); expect_out("sft.other", O_LD, 3'b010);
    sftrst = 3'b010;
    step(); expect_out("sft.own", O_DEC, 3'b000);
    sftrst = 3'b000; pkt_valid = 1'b0;
    step(); expect_out("sft.idle", O_DEC, 3'b000);

    // Back-pressure on port 0, exit via parity_done
    din = 2'd0; pkt_valid = 1'b1;
    step(); expect_out("fp.lfd", O_LFD, 3'b001);
    step(); expect_out("fp.ld", O_LD, 3'b001);
    fifo_full = 3'b001;
    step(); expect_out("fp.full", O_FULL, 3'b000);
    step(); expect_out("fp.full_hold", O_FULL, 3'b000);
    fifo_full = 3'b000;
    step(); expect_out("fp.laf", O_LAF, 3'b001);
    parity_done = 1'b1; pkt_valid = 1'b0;
    step(); expect_out("fp.dec", O_DEC, 3'b000);
    parity_done = 1'b0;

    // Back-pressure, exit via low_pkt_valid, then full again after parity
    pkt_valid = 1'b1;
    step(); step(); expect_out("fl.ld", O_LD, 3'b001);
    fifo_full = 3'b001;
    step(); expect_out("fl.full", O_FULL, 3'b000);
    fifo_full = 3'b000;
    step(); expect_out("fl.laf", O_LAF, 3'b001);
    low_pkt_valid = 1'b1;
    step(); expect_out("fl.lp", O_LP, 3'b001);
    low_pkt_valid = 1'b0; pkt_valid = 1'b0;
    step(); expect_out("fl.cpe", O_CPE, 3'b000);
    fifo_full = 3'b001;
    step(); expect_out("fl.cpe_full", O_FULL, 3'b000);
    fifo_full = 3'b000;
    step(); expect_out("fl.laf2", O_LAF, 3'b001);
    step(); expect_out("fl.ld2", O_LD, 3'b001);
    step(); expect_out("fl.lp2", O_LP, 3'b001);
    step(); step(); expect_out("fl.dec", O_DEC, 3'b000);

    // Hard reset in the middle of FIFO_FULL_STATE on port 2
    din = 2'd2; pkt_valid = 1'b1;
    step(); step(); expect_out("rst.ld", O_LD, 3'b100);
    fifo_full = 3'b100;
    step(); expect_out("rst.full", O_FULL, 3'b000);
    rstn = 1'b0;
    step(); expect_out("rst.out", O_DEC, 3'b000);
    chk("rst.addr_q", {30'd0, dut.addr_q}, 32'd0);
    rstn = 1'b1; pkt_valid = 1'b0; fifo_full = 3'b000;
    step(); expect_out("rst.idle", O_DEC, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fsm_n.md
# router_fsm_n

Parametrised packet-router control FSM for an N-output router. It sits between the input byte register block and the N output FIFOs. It decodes the header address, waits for the destination FIFO to drain, sequences first-data, payload and parity loads, and handles FIFO-full back-pressure. Unlike the fixed 3-port controller, it adds per-port write enables, invalid-address dropping, a bounded wait-for-empty timeout, and soft reset qualified to the active port.

## Interface
- NUM_PORTS, 3, number of output FIFOs (2..8)
- ADDR_W, 2, header address field width; must satisfy 2**ADDR_W >= NUM_PORTS
- WAIT_MAX, 255, max cycles in WAIT_TILL_EMPTY before the packet is dropped; 0 disables the timeout
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  reset, synchronous, active-low
- pkt_valid  in  1  packet byte valid from source
- low_pkt_valid  in  1  register block has latched the parity byte
- parity_done  in  1  register block has finished parity load
- din  in  ADDR_W  header address field (din[ADDR_W-1:0] of header byte)
- fifo_empty  in  NUM_PORTS  per-FIFO empty
- fifo_full  in  NUM_PORTS  per-FIFO full
- sftrst  in  NUM_PORTS  per-FIFO soft reset (read timeout)
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1 each  state decodes
- we_reg  out  1  register-block write enable
- busy  out  1  stall source
- write_enb  out  NUM_PORTS  one-hot FIFO write enable
- drop_state  out  1  packet being discarded
- addr_err  out  1  one-cycle pulse: invalid address
- wait_timeout  out  1  one-cycle pulse: WAIT_MAX expired

## Operation
- addr_q is loaded from din only when state==DECODE_ADDR && pkt_valid. full_sel = fifo_full[addr_q].
- DECODE_ADDR → DROP_PKT if pkt_valid && din>=NUM_PORTS (sets addr_err cause).
- DECODE_ADDR → LOAD_FIRST_DATA if pkt_valid && fifo_empty[din].
- DECODE_ADDR → WAIT_TILL_EMPTY if pkt_valid && !fifo_empty[din]; otherwise it holds.
- LOAD_FIRST_DATA → LOAD_DATA.
- WAIT_TILL_EMPTY → LOAD_FIRST_DATA if fifo_empty[addr_q].
- WAIT_TILL_EMPTY → DROP_PKT if WAIT_MAX!=0 && wait_cnt==WAIT_MAX-1 (sets timeout cause); otherwise it holds. Empty wins over timeout in the same cycle.
- LOAD_DATA → FIFO_FULL_STATE if full_sel; else LOAD_PARITY if !pkt_valid; else it holds.
- LOAD_PARITY → CHECK_PARITY_ERROR.
- FIFO_FULL_STATE → LOAD_AFTER_FULL if !full_sel; else it holds.
- LOAD_AFTER_FULL → DECODE_ADDR if parity_done; else LOAD_PARITY if low_pkt_valid; else LOAD_DATA.
- CHECK_PARITY_ERROR → FIFO_FULL_STATE if full_sel; else DECODE_ADDR.
- DROP_PKT → DECODE_ADDR when !pkt_valid. No FIFO writes occur while in DROP_PKT.
- Soft reset: sftrst[addr_q] forces DECODE_ADDR next cycle from any state except DECODE_ADDR and DROP_PKT. sftrst of any other port is ignored. Soft reset overrides all transitions and is itself overridden by rstn.
- wait_cnt, width clog2(WAIT_MAX+1), clears on every entry to WAIT_TILL_EMPTY and increments each cycle spent there.
- Decodes: busy=0 in DECODE_ADDR, LOAD_DATA and DROP_PKT, 1 elsewhere.
- we_reg=1 in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL.
- write_enb = onehot(addr_q) when (lfd_state||we_reg), else 0.
- drop_state=1 in DROP_PKT.

## Timing
- Reset: state=DECODE_ADDR, addr_q=0, wait_cnt=0.
  - Outputs after reset: detect_add=1; busy=0; all other outputs 0; write_enb=0.
- Moore outputs decoded from registered state. addr_err and wait_timeout are registered and high exactly in the first DROP_PKT cycle, according to cause.
- Header accepted with empty FIFO: lfd_state is high in cycle+1 and ld_state from cycle+2.
- Full detected in LOAD_DATA: full_state from the next cycle. write_enb drops with it.
- Timeout: with fifo_empty held 0, DROP_PKT is entered exactly WAIT_MAX cycles after WAIT_TILL_EMPTY is entered.
- Soft reset is not combinational: outputs change one cycle after sftrst is sampled.

## Test plan
- NUM_PORTS=3; header din=2, pkt_valid=1, fifo_empty=3'b111 → lfd_state at +1, ld_state at +2, write_enb=3'b100. pkt_valid=0 gives LOAD_PARITY → CHECK_PARITY_ERROR → DECODE_ADDR.
- din=3 with NUM_PORTS=3 → one addr_err pulse, drop_state high while pkt_valid=1, write_enb stays 0, DECODE_ADDR the cycle after pkt_valid falls.
- din=1, fifo_empty[1]=0, WAIT_MAX=4 → WAIT_TILL_EMPTY for 4 cycles, then DROP_PKT with a wait_timeout pulse. Repeat with fifo_empty[1] rising on cycle 3 → LOAD_FIRST_DATA and no pulse.
- In LOAD_DATA raise fifo_full[0] (addr_q=0) → full_state, busy=1, write_enb=0. Drop full → LOAD_AFTER_FULL. Then:
  - parity_done=1 → DECODE_ADDR;
  - low_pkt_valid=1 → LOAD_PARITY.
- addr_q=1 in LOAD_DATA: sftrst=3'b001 → no effect; sftrst=3'b010 → DECODE_ADDR next cycle.
- rstn=0 mid-FIFO_FULL_STATE → all outputs at reset values on next edge, addr_q=0.
